// File: rtl/sprite_mover_if.sv
// Pixel/ROM bundle between sprite_mover and its surroundings (VGA plot port plus colour ROM).
interface sprite_mover_if #(
  parameter int ADDR_W = 7
);
  // plot is a pure valid strobe with no ready: xout/yout/colourOut are meaningful only
  // while plot=1 and the sink must take one pixel in every plot cycle. rom_colour must
  // carry rom[rom_addr] in the cycle after rom_addr is presented.
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        rom_colour;
  logic [7:0]        xout;
  logic [6:0]        yout;
  logic [2:0]        colourOut;
  logic              plot;

  modport master (
    output rom_addr, xout, yout, colourOut, plot,
    input  rom_colour
  );

  modport slave (
    input  rom_addr, xout, yout, colourOut, plot,
    output rom_colour
  );
endinterface

// File: rtl/sprite_mover.sv
// Player-sprite engine: clear screen, draw sprite at home, move it left/right (erase, step, redraw).
// Define SPRITE_WRAP_EN to wrap around the screen edges instead of clamping.
module sprite_mover #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int SPRITE_W        = 11,
  parameter int SPRITE_H        = 10,
  parameter int X_HOME          = 73,
  parameter int Y_HOME          = 105,
  parameter int STEP            = 5,
  parameter int MOVE_HOLD       = 4,
  parameter int ADDR_W          = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 left,
  input  logic                 right,
  sprite_mover_if.master       pix,
  output logic                 busy,
  output logic [7:0]           x_pos,
  output logic                 hit_edge,
  output logic [2:0]           state_dbg
);

`ifdef SPRITE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(SPRITE_W * SPRITE_H);
  localparam logic [7:0]      X_LAST    = 8'(X_SCREEN_PIXELS - 1);
  localparam logic [6:0]      Y_LAST    = 7'(Y_SCREEN_PIXELS - 1);
  localparam logic [7:0]      SX_LAST   = 8'(SPRITE_W - 1);
  localparam logic [6:0]      SY_LAST   = 7'(SPRITE_H - 1);
  localparam logic [7:0]      X_HOME8   = 8'(X_HOME);
  localparam logic [6:0]      Y_HOME7   = 7'(Y_HOME);
  localparam logic [7:0]      X_MAX8    = 8'(X_SCREEN_PIXELS - SPRITE_W);
  localparam logic [8:0]      X_MAX9    = 9'(X_SCREEN_PIXELS - SPRITE_W);
  localparam logic [7:0]      STEP8     = 8'(STEP);
  localparam logic [8:0]      STEP9     = 9'(STEP);
  localparam logic [15:0]     HOLD_LAST = 16'(MOVE_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_HOME  = 3'd2,
    S_READY = 3'd3,
    S_ERASE = 3'd4,
    S_DRAW  = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        col_q, col_d;
  logic [6:0]        row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        xout_q, xout_d;
  logic [6:0]        yout_q, yout_d;
  logic              plot_q, plot_d;
  logic              rom_sel_q, rom_sel_d;
  logic              busy_q, busy_d;
  logic              hit_q, hit_d;
  logic [7:0]        x_pos_q, x_pos_d;
  logic [7:0]        nx_q, nx_d;
  logic [15:0]       hold_q, hold_d;

  logic              spr_last, clr_last;
  logic [7:0]        scol_n, ccol_n;
  logic [6:0]        srow_n, crow_n;
  logic [CNT_W-1:0]  cnt_inc;
  logic [8:0]        x9, sum9;
  logic              mv_edge;
  logic [7:0]        mv_nx;

  // Raster stepping for the full screen and for the sprite box, X fastest.
  always_comb begin
    clr_last = (col_q == X_LAST) && (row_q == Y_LAST);
    ccol_n   = col_q + 8'd1;
    crow_n   = row_q;
    if (col_q == X_LAST) begin
      ccol_n = '0;
      crow_n = (row_q == Y_LAST) ? '0 : row_q + 7'd1;
    end
    spr_last = (col_q == SX_LAST) && (row_q == SY_LAST);
    scol_n   = col_q + 8'd1;
    srow_n   = row_q;
    if (col_q == SX_LAST) begin
      scol_n = '0;
      srow_n = (row_q == SY_LAST) ? '0 : row_q + 7'd1;
    end
    cnt_inc = cnt_q + CNT_W'(1);
  end

  // Target X for a single command; 9-bit sum keeps the right-edge test free of wrap.
  always_comb begin
    x9      = {1'b0, x_pos_q};
    sum9    = x9 + STEP9;
    mv_edge = 1'b0;
    mv_nx   = x_pos_q;
    if (left) begin
      if (x9 < STEP9) begin
        mv_edge = 1'b1;
        mv_nx   = WRAP_EN ? X_MAX8 : 8'd0;
      end else begin
        mv_nx = x_pos_q - STEP8;
      end
    end else begin
      if (sum9 > X_MAX9) begin
        mv_edge = 1'b1;
        mv_nx   = WRAP_EN ? 8'd0 : X_MAX8;
      end else begin
        mv_nx = sum9[7:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    xout_d     = xout_q;
    yout_d     = yout_q;
    plot_d     = 1'b0;
    rom_sel_d  = 1'b0;
    hit_d      = 1'b0;
    x_pos_d    = x_pos_q;
    nx_d       = nx_q;
    hold_d     = hold_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_CLEAR: begin
        plot_d = 1'b1;
        xout_d = col_q;
        yout_d = row_q;
        col_d  = ccol_n;
        row_d  = crow_n;
        if (clr_last) begin
          state_d    = S_HOME;
          cnt_d      = '0;
          rom_addr_d = '0;
        end
      end
      // Address i is on rom_addr this cycle; its pixel is registered for the next one,
      // when rom_colour carries the matching ROM word.
      S_HOME, S_DRAW: begin
        if (cnt_q != N_CNT) begin
          plot_d     = 1'b1;
          rom_sel_d  = 1'b1;
          xout_d     = x_pos_q + col_q;
          yout_d     = Y_HOME7 + row_q;
          col_d      = scol_n;
          row_d      = srow_n;
          cnt_d      = cnt_inc;
          rom_addr_d = (cnt_inc == N_CNT) ? '0 : cnt_inc[ADDR_W-1:0];
        end else begin
          state_d = (state_q == S_HOME) ? S_READY : S_HOLD;
          hold_d  = '0;
        end
      end
      S_READY: begin
        if (left ^ right) begin
          if (!WRAP_EN && mv_edge && (mv_nx == x_pos_q)) begin
            hit_d   = 1'b1;
            state_d = S_HOLD;
            hold_d  = '0;
          end else begin
            hit_d   = mv_edge;
            nx_d    = mv_nx;
            state_d = S_ERASE;
            col_d   = '0;
            row_d   = '0;
          end
        end
      end
      S_ERASE: begin
        plot_d = 1'b1;
        xout_d = x_pos_q + col_q;
        yout_d = Y_HOME7 + row_q;
        col_d  = scol_n;
        row_d  = srow_n;
        if (spr_last) begin
          state_d    = S_DRAW;
          x_pos_d    = nx_q;
          cnt_d      = '0;
          rom_addr_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_READY;
        else                     hold_d  = hold_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = !((state_d == S_IDLE) || (state_d == S_READY));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      xout_q     <= '0;
      yout_q     <= '0;
      plot_q     <= 1'b0;
      rom_sel_q  <= 1'b0;
      busy_q     <= 1'b0;
      hit_q      <= 1'b0;
      x_pos_q    <= X_HOME8;
      nx_q       <= X_HOME8;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      xout_q     <= xout_d;
      yout_q     <= yout_d;
      plot_q     <= plot_d;
      rom_sel_q  <= rom_sel_d;
      busy_q     <= busy_d;
      hit_q      <= hit_d;
      x_pos_q    <= x_pos_d;
      nx_q       <= nx_d;
      hold_q     <= hold_d;
    end
  end

  assign pix.rom_addr  = rom_addr_q;
  assign pix.xout      = xout_q;
  assign pix.yout      = yout_q;
  assign pix.plot      = plot_q;
  assign pix.colourOut = rom_sel_q ? pix.rom_colour : 3'd0;
  assign busy          = busy_q;
  assign x_pos         = x_pos_q;
  assign hit_edge      = hit_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: reset, screen clear + home draw, moves, edge handling.
module tb_sprite_mover;
  localparam int W  = 11;
  localparam int H  = 10;
  localparam int N  = W * H;
  localparam int YH = 105;
  localparam int XS = 160;
  localparam int YS = 120;

  logic       clk, reset, start, left, right;
  logic       busy, hit_edge;
  logic [7:0] x_pos;
  logic [2:0] state_dbg;

  sprite_mover_if #(.ADDR_W(7)) pix_if ();

  sprite_mover #(
    .X_SCREEN_PIXELS(XS), .Y_SCREEN_PIXELS(YS), .SPRITE_W(W), .SPRITE_H(H),
    .X_HOME(73), .Y_HOME(YH), .STEP(5), .MOVE_HOLD(4), .ADDR_W(7)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .left(left), .right(right),
    .pix(pix_if), .busy(busy), .x_pos(x_pos), .hit_edge(hit_edge), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rom_mem [0:127];
  initial for (int i = 0; i < 128; i++) rom_mem[i] = 3'((i % 7) + 1);
  always @(posedge clk) pix_if.rom_colour <= rom_mem[pix_if.rom_addr];

  int n_cmp = 0;
  int n_err = 0;
  int cap_x[$], cap_y[$], cap_c[$], cap_pa[$];
  int cap_hits, cap_hold;
  bit cap_timeout;

  // Records every plotted pixel (and the rom_addr of the cycle before it) until busy falls.
  task automatic capture(input int max_cycles, input bit release_cmd);
    bit seen = 0;
    int pa = 0;
    cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_pa.delete();
    cap_hits = 0; cap_hold = 0; cap_timeout = 0;
    for (int c = 0; ; c++) begin
      if (c >= max_cycles) begin cap_timeout = 1; break; end
      @(negedge clk);
      if (c == 0 && release_cmd) begin left = 0; right = 0; start = 0; end
      if (pix_if.plot) begin
        cap_x.push_back(int'(pix_if.xout));
        cap_y.push_back(int'(pix_if.yout));
        cap_c.push_back(int'(pix_if.colourOut));
        cap_pa.push_back(pa);
      end
      if (hit_edge) cap_hits++;
      if (state_dbg == 3'd6) cap_hold++;
      pa = int'(pix_if.rom_addr);
      if (busy) seen = 1;
      else if (seen) break;
    end
  endtask

  // Number of captured pixels from index base that differ from a sprite box at x0.
  function automatic int sprite_bad(input int base, input int x0, input bit use_rom);
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      int k = base + i;
      if (k >= cap_x.size()) begin bad++; continue; end
      if (cap_x[k] != x0 + i % W || cap_y[k] != YH + i / W ||
          cap_c[k] != (use_rom ? int'(rom_mem[i]) : 0) || (use_rom && cap_pa[k] != i))
        bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    reset = 0; start = 0; left = 0; right = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pix_if.plot !== 1'b0) begin n_err++; $display("FAIL rst_plot: got %0d expected 0", pix_if.plot); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0d expected 0", busy); end
    n_cmp++; if (hit_edge !== 1'b0) begin n_err++; $display("FAIL rst_hit: got %0d expected 0", hit_edge); end
    n_cmp++; if (x_pos !== 8'd73) begin n_err++; $display("FAIL rst_xpos: got %0d expected 73", x_pos); end
    n_cmp++; if ({pix_if.xout, pix_if.yout, pix_if.colourOut} !== 18'd0) begin
      n_err++; $display("FAIL rst_pixel: got %0d/%0d/%0d expected 0/0/0", pix_if.xout, pix_if.yout, pix_if.colourOut); end
    n_cmp++; if (pix_if.rom_addr !== 7'd0) begin n_err++; $display("FAIL rst_addr: got %0d expected 0", pix_if.rom_addr); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
    reset = 1;
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk); start = 1;
    repeat (50) @(negedge clk);
    n_cmp++; if ({pix_if.plot, busy} !== 2'b11) begin n_err++; $display("FAIL midclr_active: got %0d%0d expected 11", pix_if.plot, busy); end
    #2 reset = 0;
    #1;
    n_cmp++; if ({pix_if.plot, busy} !== 2'b00) begin n_err++; $display("FAIL midclr_async: got %0d%0d expected 00", pix_if.plot, busy); end
    n_cmp++; if (x_pos !== 8'd73) begin n_err++; $display("FAIL midclr_xpos: got %0d expected 73", x_pos); end
    start = 0;
    @(negedge clk); reset = 1;
    repeat (5) @(negedge clk);
    n_cmp++; if ({pix_if.plot, busy, state_dbg} !== 5'b00000) begin
      n_err++; $display("FAIL midclr_idle: got plot=%0d busy=%0d state=%0d expected 0/0/0", pix_if.plot, busy, state_dbg); end
  endtask

  task automatic test_init();
    int bad = 0;
    start = 1;
    capture(25000, 1);
    n_cmp++; if (cap_timeout) begin n_err++; $display("FAIL init_timeout: got 1 expected 0"); end
    n_cmp++; if (cap_x.size() != XS * YS + N) begin n_err++; $display("FAIL init_plots: got %0d expected %0d", cap_x.size(), XS * YS + N); end
    for (int k = 0; k < XS * YS && k < cap_x.size(); k++)
      if (cap_x[k] != k % XS || cap_y[k] != k / XS || cap_c[k] != 0) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL init_clear_pixels: got %0d bad expected 0", bad); end
    bad = sprite_bad(XS * YS, 73, 1);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL init_home_sprite: got %0d bad expected 0", bad); end
    n_cmp++; if ({busy, state_dbg} !== 4'b0011) begin n_err++; $display("FAIL init_ready: got busy=%0d state=%0d expected 0/3", busy, state_dbg); end
  endtask

  task automatic test_move_left();
    left = 1;
    capture(2000, 1);
    n_cmp++; if (cap_timeout || cap_x.size() != 2 * N) begin n_err++; $display("FAIL mv1_plots: got %0d expected %0d", cap_x.size(), 2 * N); end
    n_cmp++; if (sprite_bad(0, 73, 0) != 0) begin n_err++; $display("FAIL mv1_erase: got %0d bad expected 0", sprite_bad(0, 73, 0)); end
    n_cmp++; if (sprite_bad(N, 68, 1) != 0) begin n_err++; $display("FAIL mv1_draw: got %0d bad expected 0", sprite_bad(N, 68, 1)); end
    n_cmp++; if (x_pos !== 8'd68) begin n_err++; $display("FAIL mv1_xpos: got %0d expected 68", x_pos); end
    n_cmp++; if (cap_hold != 4 || cap_hits != 0) begin n_err++; $display("FAIL mv1_hold: got hold=%0d hits=%0d expected 4/0", cap_hold, cap_hits); end
    left = 1;
    capture(2000, 0);
    left = 0;
    n_cmp++; if (cap_timeout || cap_x.size() != 2 * N) begin n_err++; $display("FAIL mv2_plots: got %0d expected %0d", cap_x.size(), 2 * N); end
    n_cmp++; if (sprite_bad(N, 63, 1) != 0) begin n_err++; $display("FAIL mv2_draw: got %0d bad expected 0", sprite_bad(N, 63, 1)); end
    n_cmp++; if (x_pos !== 8'd63 || cap_hold != 4) begin n_err++; $display("FAIL mv2_held: got x=%0d hold=%0d expected 63/4", x_pos, cap_hold); end
  endtask

  task automatic test_both_keys();
    int plots = 0, busies = 0;
    left = 1; right = 1;
    repeat (6) begin
      @(negedge clk);
      if (pix_if.plot) plots++;
      if (busy) busies++;
    end
    left = 0; right = 0;
    n_cmp++; if (plots != 0 || busies != 0) begin n_err++; $display("FAIL both_keys: got plots=%0d busy=%0d expected 0/0", plots, busies); end
    n_cmp++; if (x_pos !== 8'd63) begin n_err++; $display("FAIL both_xpos: got %0d expected 63", x_pos); end
  endtask

  task automatic step_n(input bit go_left, input int n, output int bad_moves);
    bad_moves = 0;
    for (int i = 0; i < n; i++) begin
      left = go_left; right = !go_left;
      capture(2000, 1);
      if (cap_timeout || cap_x.size() != 2 * N || cap_hits != 0) bad_moves++;
    end
  endtask

`ifndef SPRITE_WRAP_EN
  task automatic test_clamp();
    int bad;
    step_n(1, 12, bad);
    n_cmp++; if (bad != 0 || x_pos !== 8'd3) begin n_err++; $display("FAIL clamp_walk_left: got bad=%0d x=%0d expected 0/3", bad, x_pos); end
    left = 1; capture(2000, 1);
    n_cmp++; if (x_pos !== 8'd0 || cap_hits != 1 || cap_x.size() != 2 * N) begin
      n_err++; $display("FAIL clamp_left_edge: got x=%0d hits=%0d plots=%0d expected 0/1/220", x_pos, cap_hits, cap_x.size()); end
    n_cmp++; if (sprite_bad(0, 3, 0) + sprite_bad(N, 0, 1) != 0) begin n_err++; $display("FAIL clamp_left_pixels: got %0d bad expected 0", sprite_bad(0, 3, 0) + sprite_bad(N, 0, 1)); end
    left = 1; capture(2000, 1);
    n_cmp++; if (x_pos !== 8'd0 || cap_hits != 1 || cap_x.size() != 0 || cap_hold != 4 || cap_timeout) begin
      n_err++; $display("FAIL clamp_left_blocked: got x=%0d hits=%0d plots=%0d hold=%0d expected 0/1/0/4", x_pos, cap_hits, cap_x.size(), cap_hold); end
    step_n(0, 29, bad);
    n_cmp++; if (bad != 0 || x_pos !== 8'd145) begin n_err++; $display("FAIL clamp_walk_right: got bad=%0d x=%0d expected 0/145", bad, x_pos); end
    right = 1; capture(2000, 1);
    n_cmp++; if (x_pos !== 8'd149 || cap_hits != 1 || sprite_bad(N, 149, 1) != 0) begin
      n_err++; $display("FAIL clamp_right_edge: got x=%0d hits=%0d expected 149/1", x_pos, cap_hits); end
    right = 1; capture(2000, 1);
    n_cmp++; if (x_pos !== 8'd149 || cap_hits != 1 || cap_x.size() != 0) begin
      n_err++; $display("FAIL clamp_right_blocked: got x=%0d hits=%0d plots=%0d expected 149/1/0", x_pos, cap_hits, cap_x.size()); end
  endtask
`else
  task automatic test_wrap();
    int bad;
    step_n(0, 17, bad);
    n_cmp++; if (bad != 0 || x_pos !== 8'd148) begin n_err++; $display("FAIL wrap_walk_right: got bad=%0d x=%0d expected 0/148", bad, x_pos); end
    right = 1; capture(2000, 1);
    n_cmp++; if (x_pos !== 8'd0 || cap_hits != 1 || sprite_bad(N, 0, 1) != 0) begin
      n_err++; $display("FAIL wrap_right_edge: got x=%0d hits=%0d expected 0/1", x_pos, cap_hits); end
    left = 1; capture(2000, 1);
    n_cmp++; if (x_pos !== 8'd149 || cap_hits != 1 || cap_x.size() != 2 * N) begin
      n_err++; $display("FAIL wrap_left_edge: got x=%0d hits=%0d plots=%0d expected 149/1/220", x_pos, cap_hits, cap_x.size()); end
    n_cmp++; if (sprite_bad(0, 0, 0) + sprite_bad(N, 149, 1) != 0) begin
      n_err++; $display("FAIL wrap_left_pixels: got %0d bad expected 0", sprite_bad(0, 0, 0) + sprite_bad(N, 149, 1)); end
    right = 1; capture(2000, 1);
    n_cmp++; if (x_pos !== 8'd0 || cap_hits != 1) begin n_err++; $display("FAIL wrap_right_again: got x=%0d hits=%0d expected 0/1", x_pos, cap_hits); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_clear();
    test_init();
    test_move_left();
    test_both_keys();
`ifndef SPRITE_WRAP_EN
    test_clamp();
`else
    test_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
